// File: rtl/ycr_dmem_wb_bridge_if.sv
// Signal bundle between the dmem router port, the bridge and the Wishbone data bus.
// slave = bridge view (accepts dmem requests, masters the wb cycle); master = requester/bus view.
interface ycr_dmem_wb_bridge_if;
    logic        dmem_req_ack;
    logic        dmem_req;
    logic        dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;

    logic        wbd_cyc_o;
    logic        wbd_stb_o;
    logic        wbd_we_o;
    logic [31:0] wbd_adr_o;
    logic [3:0]  wbd_sel_o;
    logic [31:0] wbd_dat_o;
    logic [31:0] wbd_dat_i;
    logic        wbd_ack_i;
    logic        wbd_err_i;

    modport slave (
        output dmem_req_ack, dmem_rdata, dmem_resp,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output wbd_cyc_o, wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_sel_o, wbd_dat_o,
        input  wbd_dat_i, wbd_ack_i, wbd_err_i
    );

    modport master (
        input  dmem_req_ack, dmem_rdata, dmem_resp,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  wbd_cyc_o, wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_sel_o, wbd_dat_o,
        output wbd_dat_i, wbd_ack_i, wbd_err_i
    );
endinterface

// File: rtl/ycr_dmem_wb_bridge.sv
// Core dmem req/resp to single-outstanding Wishbone classic master bridge with
// alignment checking, byte-lane steering and a bus timeout.
module ycr_dmem_wb_bridge #(
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ycr_dmem_wb_bridge_if.slave    bus
);

    localparam logic [1:0] RespNotRdy = 2'b00;
    localparam logic [1:0] RespRdyOk  = 2'b01;
    localparam logic [1:0] RespRdyEr  = 2'b10;

    localparam bit              TmoEn   = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] TmoLast = (TMO_CYC == 0) ? '0 : TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [31:0]       adr_q, adr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       dat_q, dat_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;

    logic req_ack;
    logic accept;
    logic misaligned;
    logic [3:0] sel_req;

    assign req_ack = (state_q == StIdle) || (state_q == StResp);
    assign accept  = bus.dmem_req && req_ack;

    always_comb begin
        misaligned = 1'b0;
        sel_req    = 4'b1111;
        unique case (bus.dmem_width)
            2'b00: sel_req = 4'b0001 << bus.dmem_addr[1:0];
            2'b01: begin
                sel_req    = 4'b0011 << bus.dmem_addr[1:0];
                misaligned = bus.dmem_addr[0];
            end
            2'b10: misaligned = (bus.dmem_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle, StResp: begin
                resp_d = RespNotRdy;
                if (!accept) begin
                    state_d = StIdle;
                end else if (misaligned) begin
                    // Rejected without touching the bus: error response next cycle.
                    state_d = StResp;
                    resp_d  = RespRdyEr;
                end else begin
                    state_d = StBus;
                    cyc_d   = 1'b1;
                    we_d    = bus.dmem_cmd;
                    adr_d   = {bus.dmem_addr[31:2], 2'b00};
                    sel_d   = sel_req;
                    dat_d   = bus.dmem_wdata << {bus.dmem_addr[1:0], 3'b000};
                    off_d   = bus.dmem_addr[1:0];
                    cnt_d   = '0;
                end
            end
            StBus: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (bus.wbd_err_i) begin
                    state_d = StResp;
                    cyc_d   = 1'b0;
                    resp_d  = RespRdyEr;
                end else if (bus.wbd_ack_i) begin
                    state_d = StResp;
                    cyc_d   = 1'b0;
                    resp_d  = RespRdyOk;
                    rdata_d = we_q ? 32'h0 : (bus.wbd_dat_i >> {off_q, 3'b000});
                end else if (TmoEn && (cnt_q == TmoLast)) begin
                    state_d = StResp;
                    cyc_d   = 1'b0;
                    resp_d  = RespRdyEr;
                end
            end
            default: begin
                state_d = StIdle;
                cyc_d   = 1'b0;
                resp_d  = RespNotRdy;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            resp_q  <= RespNotRdy;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.dmem_req_ack = req_ack;
    assign bus.dmem_rdata   = rdata_q;
    assign bus.dmem_resp    = resp_q;
    assign bus.wbd_cyc_o    = cyc_q;
    assign bus.wbd_stb_o    = cyc_q;
    assign bus.wbd_we_o     = we_q;
    assign bus.wbd_adr_o    = adr_q;
    assign bus.wbd_sel_o    = sel_q;
    assign bus.wbd_dat_o    = dat_q;

endmodule

// File: tb/tb_ycr_dmem_wb_bridge.sv
// Directed self-checking bench for ycr_dmem_wb_bridge (timeout shortened to 4 cycles).
module tb_ycr_dmem_wb_bridge;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ycr_dmem_wb_bridge_if dif ();

    ycr_dmem_wb_bridge #(
        .TMO_W   (8),
        .TMO_CYC (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, confirm it is acknowledged, take the accepting edge, drop req.
    task automatic issue(input logic cmd, input logic [1:0] width, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
        dif.dmem_req   = 1'b1;
        dif.dmem_cmd   = cmd;
        dif.dmem_width = width;
        dif.dmem_addr  = addr;
        dif.dmem_wdata = wdata;
        #1;
        check({tag, " req_ack"}, 32'(dif.dmem_req_ack), 32'h1);
        tick();
        dif.dmem_req = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n          = 1'b0;
        dif.dmem_req   = 1'b0;
        dif.dmem_cmd   = 1'b0;
        dif.dmem_width = 2'b00;
        dif.dmem_addr  = 32'h0;
        dif.dmem_wdata = 32'h0;
        dif.wbd_dat_i  = 32'h0;
        dif.wbd_ack_i  = 1'b0;
        dif.wbd_err_i  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst cyc", 32'(dif.wbd_cyc_o), 32'h0);
        check("rst stb", 32'(dif.wbd_stb_o), 32'h0);
        check("rst resp", 32'(dif.dmem_resp), 32'h0);
        check("rst rdata", dif.dmem_rdata, 32'h0);
        check("rst sel", 32'(dif.wbd_sel_o), 32'h0);
        check("rst adr", dif.wbd_adr_o, 32'h0);
        check("rst req_ack", 32'(dif.dmem_req_ack), 32'h1);
        rst_n = 1'b1;
        tick();

        // RD WORD @0x1000_0004, ack in second BUS cycle
        issue(1'b0, 2'b10, 32'h1000_0004, 32'h0, "rdw");
        check("rdw cyc", 32'(dif.wbd_cyc_o), 32'h1);
        check("rdw stb", 32'(dif.wbd_stb_o), 32'h1);
        check("rdw we", 32'(dif.wbd_we_o), 32'h0);
        check("rdw sel", 32'(dif.wbd_sel_o), 32'hf);
        check("rdw adr", dif.wbd_adr_o, 32'h1000_0004);
        check("rdw busy req_ack", 32'(dif.dmem_req_ack), 32'h0);
        check("rdw busy resp", 32'(dif.dmem_resp), 32'h0);
        tick();
        check("rdw cyc hold", 32'(dif.wbd_cyc_o), 32'h1);
        dif.wbd_ack_i = 1'b1;
        dif.wbd_dat_i = 32'hDEAD_BEEF;
        tick();
        dif.wbd_ack_i = 1'b0;
        dif.wbd_dat_i = 32'h0;
        check("rdw resp", 32'(dif.dmem_resp), 32'h1);
        check("rdw rdata", dif.dmem_rdata, 32'hDEAD_BEEF);
        check("rdw cyc drop", 32'(dif.wbd_cyc_o), 32'h0);
        check("rdw resp req_ack", 32'(dif.dmem_req_ack), 32'h1);
        tick();
        check("rdw resp one cycle", 32'(dif.dmem_resp), 32'h0);
        check("rdw rdata hold", dif.dmem_rdata, 32'hDEAD_BEEF);

        // WR BYTE @..03
        issue(1'b1, 2'b00, 32'h1000_0003, 32'h0000_005A, "wrb");
        check("wrb sel", 32'(dif.wbd_sel_o), 32'h8);
        check("wrb dat_o", dif.wbd_dat_o, 32'h5A00_0000);
        check("wrb we", 32'(dif.wbd_we_o), 32'h1);
        check("wrb adr", dif.wbd_adr_o, 32'h1000_0000);
        dif.wbd_ack_i = 1'b1;
        tick();
        dif.wbd_ack_i = 1'b0;
        check("wrb resp", 32'(dif.dmem_resp), 32'h1);
        check("wrb rdata zero", dif.dmem_rdata, 32'h0);
        tick();

        // RD HWORD @..02
        issue(1'b0, 2'b01, 32'h1000_0002, 32'h0, "rdh");
        check("rdh sel", 32'(dif.wbd_sel_o), 32'hc);
        dif.wbd_ack_i = 1'b1;
        dif.wbd_dat_i = 32'hABCD_1234;
        tick();
        dif.wbd_ack_i = 1'b0;
        check("rdh resp", 32'(dif.dmem_resp), 32'h1);
        check("rdh rdata", dif.dmem_rdata, 32'h0000_ABCD);
        tick();

        // Misaligned WORD @..02: no bus cycle
        issue(1'b0, 2'b10, 32'h1000_0002, 32'h0, "mis");
        check("mis cyc", 32'(dif.wbd_cyc_o), 32'h0);
        check("mis resp", 32'(dif.dmem_resp), 32'h2);
        tick();
        check("mis cyc after", 32'(dif.wbd_cyc_o), 32'h0);
        check("mis resp clear", 32'(dif.dmem_resp), 32'h0);

        // Misaligned HWORD @..01 and width=ERROR
        issue(1'b0, 2'b01, 32'h0000_0001, 32'h0, "mish");
        check("mish resp", 32'(dif.dmem_resp), 32'h2);
        check("mish cyc", 32'(dif.wbd_cyc_o), 32'h0);
        tick();
        issue(1'b1, 2'b11, 32'h0000_0000, 32'h0, "wer");
        check("wer resp", 32'(dif.dmem_resp), 32'h2);
        check("wer cyc", 32'(dif.wbd_cyc_o), 32'h0);
        tick();

        // err (together with ack) during BUS
        issue(1'b0, 2'b10, 32'h0000_0020, 32'h0, "err");
        dif.wbd_ack_i = 1'b1;
        dif.wbd_err_i = 1'b1;
        dif.wbd_dat_i = 32'h5555_5555;
        tick();
        dif.wbd_ack_i = 1'b0;
        dif.wbd_err_i = 1'b0;
        check("err resp", 32'(dif.dmem_resp), 32'h2);
        check("err cyc", 32'(dif.wbd_cyc_o), 32'h0);
        check("err rdata hold", dif.dmem_rdata, 32'h0000_ABCD);
        tick();
        issue(1'b0, 2'b10, 32'h0000_0024, 32'h0, "aft");
        check("aft cyc", 32'(dif.wbd_cyc_o), 32'h1);
        dif.wbd_ack_i = 1'b1;
        dif.wbd_dat_i = 32'h1122_3344;
        tick();
        dif.wbd_ack_i = 1'b0;
        check("aft resp", 32'(dif.dmem_resp), 32'h1);
        check("aft rdata", dif.dmem_rdata, 32'h1122_3344);
        tick();

        // Timeout after 4 BUS cycles
        issue(1'b0, 2'b10, 32'h0000_0030, 32'h0, "tmo");
        check("tmo cyc c1", 32'(dif.wbd_cyc_o), 32'h1);
        tick();
        tick();
        tick();
        check("tmo cyc c4", 32'(dif.wbd_stb_o), 32'h1);
        check("tmo resp c4", 32'(dif.dmem_resp), 32'h0);
        tick();
        check("tmo stb drop", 32'(dif.wbd_stb_o), 32'h0);
        check("tmo resp", 32'(dif.dmem_resp), 32'h2);
        tick();
        check("tmo idle resp", 32'(dif.dmem_resp), 32'h0);
        dif.wbd_ack_i = 1'b1;
        dif.wbd_dat_i = 32'hFFFF_FFFF;
        tick();
        dif.wbd_ack_i = 1'b0;
        check("stray resp", 32'(dif.dmem_resp), 32'h0);
        check("stray cyc", 32'(dif.wbd_cyc_o), 32'h0);
        check("stray rdata", dif.dmem_rdata, 32'h1122_3344);
        tick();

        // Back-to-back with req held high
        dif.dmem_req   = 1'b1;
        dif.dmem_cmd   = 1'b0;
        dif.dmem_width = 2'b10;
        dif.dmem_addr  = 32'h0000_0040;
        tick();
        check("b2b bus req_ack", 32'(dif.dmem_req_ack), 32'h0);
        check("b2b stb1", 32'(dif.wbd_stb_o), 32'h1);
        dif.wbd_ack_i = 1'b1;
        dif.wbd_dat_i = 32'hCAFE_F00D;
        tick();
        dif.wbd_ack_i = 1'b0;
        dif.dmem_addr = 32'h0000_0044;
        #1;
        check("b2b resp", 32'(dif.dmem_resp), 32'h1);
        check("b2b rdata", dif.dmem_rdata, 32'hCAFE_F00D);
        check("b2b resp req_ack", 32'(dif.dmem_req_ack), 32'h1);
        check("b2b stb gap", 32'(dif.wbd_stb_o), 32'h0);
        tick();
        dif.dmem_req = 1'b0;
        check("b2b stb2", 32'(dif.wbd_stb_o), 32'h1);
        check("b2b adr2", dif.wbd_adr_o, 32'h0000_0044);

        // Asynchronous reset mid-BUS
        #2;
        rst_n = 1'b0;
        #1;
        check("arst cyc", 32'(dif.wbd_cyc_o), 32'h0);
        check("arst resp", 32'(dif.dmem_resp), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst idle cyc", 32'(dif.wbd_cyc_o), 32'h0);
        check("arst idle resp", 32'(dif.dmem_resp), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
